// File: rtl/btn_conditioner.sv
`timescale 1ns/1ps
// btn_conditioner: synchronises, debounces and edge-detects four push-buttons, adds
// auto-repeat on selected buttons, and arbitrates opposing pairs so they never strobe together.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 512,
  parameter int unsigned REPEAT_DELAY    = 5_000_000,
  parameter int unsigned REPEAT_PERIOD   = 2_000_000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b1100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       btn_conflict
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]   DELAY_MAX  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0]   PERIOD_MAX = 24'(REPEAT_PERIOD - 1);

  logic [3:0] s1_reg;
  logic [3:0] s2_reg;
  logic [3:0] cand;
  logic [1:0] clash;
  logic [3:0] press_next;
  logic       conflict_next;
  logic [3:0] press_reg;
  logic       conflict_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_btn
    logic [DW-1:0] dcnt_reg;
    logic [DW-1:0] dcnt_next;
    logic          level_reg;
    logic          level_next;
    logic          accept;
    logic          rep_pulse;

    // Any cycle where the synchronised input agrees with the level restarts the count.
    always_comb begin
      dcnt_next  = dcnt_reg;
      level_next = level_reg;
      accept     = 1'b0;
      if (s2_reg[gi] == level_reg) begin
        dcnt_next = '0;
      end else if (dcnt_reg == DCNT_MAX) begin
        level_next = s2_reg[gi];
        dcnt_next  = '0;
        accept     = 1'b1;
      end else begin
        dcnt_next = dcnt_reg + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_reg  <= '0;
        level_reg <= 1'b0;
      end else begin
        dcnt_reg  <= dcnt_next;
        level_reg <= level_next;
      end
    end

    if (REPEAT_MASK[gi]) begin : g_rep
      logic [23:0] rcnt_reg;
      logic [23:0] rcnt_next;
      logic        rep_reg;
      logic        rep_next;
      logic        fire;

      // rcnt measures time since the press (rep=0) or since the last repeat (rep=1).
      always_comb begin
        rcnt_next = rcnt_reg;
        rep_next  = rep_reg;
        fire      = 1'b0;
        if (!level_reg) begin
          rcnt_next = '0;
          rep_next  = 1'b0;
        end else if (!rep_reg && (rcnt_reg == DELAY_MAX)) begin
          fire      = 1'b1;
          rcnt_next = '0;
          rep_next  = 1'b1;
        end else if (rep_reg && (rcnt_reg == PERIOD_MAX)) begin
          fire      = 1'b1;
          rcnt_next = '0;
        end else begin
          rcnt_next = rcnt_reg + 24'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_reg <= '0;
          rep_reg  <= 1'b0;
        end else begin
          rcnt_reg <= rcnt_next;
          rep_reg  <= rep_next;
        end
      end

      assign rep_pulse = fire;
    end else begin : g_norep
      assign rep_pulse = 1'b0;
    end

    // A press is the accepting edge of a 0->1 level change.
    assign cand[gi]      = (accept & s2_reg[gi]) | rep_pulse;
    assign btn_level[gi] = level_reg;
  end

  for (gi = 0; gi < 2; gi++) begin : g_pair
    assign clash[gi]             = cand[2*gi] & cand[2*gi+1];
    assign press_next[2*gi +: 2] = clash[gi] ? 2'b00 : cand[2*gi +: 2];
  end

  assign conflict_next = |clash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_reg    <= '0;
      conflict_reg <= 1'b0;
    end else begin
      press_reg    <= press_next;
      conflict_reg <= conflict_next;
    end
  end

  assign btn_press    = press_reg;
  assign btn_conflict = conflict_reg;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end input conditioner for the four user push-buttons on `ui_in[3:0]`: next animation, previous animation, speed up and speed down. It synchronises each raw input, debounces it with a consecutive-stability counter, and emits single-cycle press pulses, with auto-repeat on selected buttons. It sits directly upstream of the animation/speed control logic, which consumes `btn_press` as clean one-cycle strobes.

## Interface
- `DEBOUNCE_CYCLES`, 512: consecutive synchronised cycles a new level must hold before it is accepted; must be ≥ 1.
- `REPEAT_DELAY`, 5_000_000: cycles from a press pulse to the first auto-repeat pulse; must be ≥ 1.
- `REPEAT_PERIOD`, 2_000_000: cycles between subsequent auto-repeat pulses; must be ≥ 1.
- `REPEAT_MASK`, 4'b1100: per-button auto-repeat enable; the speed buttons repeat by default.

Ports:
- `clk`  in  1: system clock, 10 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_raw`  in  4: raw button levels, asynchronous to `clk`. Bit 0 is next, bit 1 is previous, bit 2 is speed up, bit 3 is speed down.
- `btn_level`  out  4: debounced stable level per button.
- `btn_press`  out  4: one-cycle strobe per accepted press or repeat, after pair arbitration.
- `btn_conflict`  out  1: one-cycle strobe when arbitration dropped at least one pulse.

## Operation
- **Synchroniser.** Each bit passes through two flops (`s1`, then `s2`); `s2` is the synchronised level `s`.
- **Debounce, per button.** Counter `dcnt` is `clog2(DEBOUNCE_CYCLES)` bits wide, with a minimum of 1 bit.
  - If `s == level`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `level <= s` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - Any single-cycle glitch back to `level` restarts the count.
- **Press detection.** A raw press is registered when `level` goes 0→1. `raw_press <= s & ~level` on the accepting edge, so the pulse coincides with the first cycle `btn_level` is high.
- **Auto-repeat, per button with `REPEAT_MASK[i]`=1.** Uses a 24-bit counter `rcnt` and a flag `rep` (0 = waiting for the first repeat, 1 = periodic).
  - On press: `rcnt <= 0`, `rep <= 0`.
  - While `level` is 1: `rcnt` increments.
  - When `rep`=0 and `rcnt == REPEAT_DELAY-1`: emit a pulse, set `rcnt <= 0` and `rep <= 1`.
  - When `rep`=1 and `rcnt == REPEAT_PERIOD-1`: emit a pulse and set `rcnt <= 0`.
  - When `level` is 0: `rcnt <= 0` and `rep <= 0`.
  - For masked-off buttons, `rcnt` is held at 0.
- **Pair arbitration.** The pairs are bits {0,1} and {2,3}.
  - If both members of a pair have a candidate pulse (press or repeat) in the same cycle, both are dropped for that pair and `btn_conflict` pulses.
  - The other pair is unaffected.
- **Output registers.** `btn_press` and `btn_conflict` are registered; `btn_level` is the debounce register.
- **Release.** A 1→0 level change is debounced identically but produces no pulse.

## Timing
- **Reset values.** While `rst_n`=0, all of the following are 0: synchroniser flops, `dcnt`, `rcnt`, `rep`, `btn_level`, `btn_press`, `btn_conflict`. Reset takes effect immediately, without waiting for a clock edge.
- **Press latency.** Let edge 1 be the first rising edge sampling `btn_raw[i]`=1. If the input stays high, `btn_level[i]` and `btn_press[i]` go high after edge `DEBOUNCE_CYCLES+2`.
- **Press pulse width.** `btn_press[i]` stays high for exactly one cycle.
- **Release latency.** The same `DEBOUNCE_CYCLES+2` edges apply to the falling level.
- **First repeat.** It occurs `REPEAT_DELAY` cycles after the press pulse.
- **Later repeats.** Each occurs `REPEAT_PERIOD` cycles after the previous one, for as long as `btn_level` stays 1.
- **Reset mid-operation.** All state clears. If `btn_raw` is still high after reset, a fresh full debounce runs and yields a new press pulse.
- **Simultaneous buttons across pairs.** Presses on buttons from different pairs, e.g. 0 and 2 in the same cycle, both appear.
- **Counter limits.** Counters never wrap: `dcnt` is bounded by the accept condition, and `rcnt` is bounded by the compare values. Parameters must fit in 24 bits.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `REPEAT_MASK`=4'b1100.

1. **Clean press.** `btn_raw[0]` goes 0→1 and is held for 40 cycles. Required: `btn_level[0]` high after edge 10, `btn_press[0]` high for exactly that one cycle, and no further pulses (bit 0 is masked off).
2. **Bounce rejection.** `btn_raw[1]` is high for 7 cycles, low for 1 cycle, then high for 7 cycles, then low. Required: `btn_level[1]` stays 0 and `btn_press[1]` never pulses.
3. **Auto-repeat.** `btn_raw[2]` is held high for 60 cycles after acceptance. Required: press pulse at T, repeats at T+20, T+25, T+30 and so on. After release plus 10 edges, `btn_level[2]`=0 and no further pulses.
4. **Conflict.** `btn_raw[2]` and `btn_raw[3]` rise on the same edge. Required: `btn_press[3:2]` stays 00 and `btn_conflict` pulses once at the accept edge. The same conflict occurs at each shared repeat.
5. **Cross-pair independence.** `btn_raw[0]` and `btn_raw[2]` rise on the same edge. Required: `btn_press`=4'b0101 for one cycle and `btn_conflict`=0.
6. **Reset mid-hold.** Hold `btn_raw[3]`, assert `rst_n`=0 for 3 cycles at accept+12, then release reset. Required: all outputs are 0 immediately when reset asserts, and a new press pulse appears 10 edges after reset is released.
